// File: rtl/fpnew_sdotp_result_collector.sv
// Minimal FP format/status package used by the SDOTP result collector,
// followed by the collector itself: a small FIFO that NaN-boxes results
// at push time, keeps sticky exception flags, and drives writeback.

package fpnew_pkg;

    localparam int unsigned NUM_FP_FORMATS = 6;

    typedef enum logic [2:0] {
        FP32    = 3'd0,
        FP64    = 3'd1,
        FP16    = 3'd2,
        FP8     = 3'd3,
        FP16ALT = 3'd4,
        FP8ALT  = 3'd5
    } fp_format_e;

    typedef logic [0:NUM_FP_FORMATS-1] fmt_logic_t;

    typedef struct packed {
        logic NV;
        logic DZ;
        logic OF;
        logic UF;
        logic NX;
    } status_t;

    function automatic int unsigned fp_width(input fp_format_e fmt);
        case (fmt)
            FP32:    return 32;
            FP64:    return 64;
            FP16:    return 16;
            FP8:     return 8;
            FP16ALT: return 16;
            FP8ALT:  return 8;
            default: return 0;
        endcase
    endfunction

endpackage

module fpnew_sdotp_result_collector #(
    parameter int unsigned         FLEN           = 64,
    parameter fpnew_pkg::fmt_logic_t FpDstFmtConfig = '1,
    parameter int unsigned         Depth          = 2,
    parameter type                 TagType        = logic,
    localparam int unsigned        CntW           = $clog2(Depth + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [FLEN-1:0]      result_i,
    input  fpnew_pkg::status_t   status_i,
    input  logic                 extension_bit_i,
    input  fpnew_pkg::fp_format_e dst_fmt_i,
    input  TagType               tag_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [FLEN-1:0]      result_o,
    output fpnew_pkg::status_t   status_o,
    output logic                 extension_bit_o,
    output TagType               tag_o,
    output fpnew_pkg::status_t   fflags_o,
    input  logic                 fflags_clr_i,
    output logic [CntW-1:0]      count_o,
    output logic                 busy_o
);
    import fpnew_pkg::*;

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned StW  = $bits(status_t);

    // Storage: written only on an accepted, non-flushed push
    logic [FLEN-1:0] res_mem [Depth];
    status_t         st_mem  [Depth];
    logic            ext_mem [Depth];
    TagType          tag_mem [Depth];

    logic [PtrW-1:0] rd_q, wr_q, rd_nxt, wr_nxt;
    logic [CntW-1:0] cnt_q;
    status_t         fflags_q;
    logic            push, pop;

    // Boxing masks: one term per enabled format narrower than the bus,
    // OR-chained so only the matching format contributes its upper ones.
    logic [FLEN-1:0] mask_acc [NUM_FP_FORMATS+1];
    logic [FLEN-1:0] boxed;

    assign mask_acc[0] = '0;

    for (genvar g = 0; g < NUM_FP_FORMATS; g++) begin : g_box
        localparam int unsigned W   = fp_width(fp_format_e'(g));
        localparam bit          BOX = FpDstFmtConfig[g] && (W > 0) && (W < FLEN);
        logic hit;
        assign hit = BOX && (dst_fmt_i == fp_format_e'(g));
        assign mask_acc[g+1] = mask_acc[g] | (hit ? ({FLEN{1'b1}} << W) : '0);
    end

    assign boxed = result_i | mask_acc[NUM_FP_FORMATS];

    // Handshakes; ready depends only on occupancy, never on out_ready_i
    assign in_ready_o  = (cnt_q < CntW'(Depth));
    assign out_valid_o = (cnt_q != '0);
    assign push        = in_valid_i && in_ready_o;
    assign pop         = out_valid_o && out_ready_i;

    assign rd_nxt = (rd_q == PtrW'(Depth - 1)) ? '0 : rd_q + 1'b1;
    assign wr_nxt = (wr_q == PtrW'(Depth - 1)) ? '0 : wr_q + 1'b1;

    // Sticky flag next-state: clear applies before the popped status is merged
    logic [StW-1:0] fl_next;
    always_comb begin
        fl_next = fflags_clr_i ? '0 : fflags_q;
        if (pop) fl_next = fl_next | st_mem[rd_q];
    end

    // Pointer, occupancy and sticky flag state; reset beats flush beats push/pop
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_q     <= '0;
            wr_q     <= '0;
            cnt_q    <= '0;
            fflags_q <= '0;
        end else begin
            fflags_q <= status_t'(fl_next);
            if (flush_i) begin
                rd_q  <= '0;
                wr_q  <= '0;
                cnt_q <= '0;
            end else begin
                if (push) wr_q <= wr_nxt;
                if (pop)  rd_q <= rd_nxt;
                case ({push, pop})
                    2'b10:   cnt_q <= cnt_q + 1'b1;
                    2'b01:   cnt_q <= cnt_q - 1'b1;
                    default: cnt_q <= cnt_q;
                endcase
            end
        end
    end

    // Entry write: boxed result plus verbatim side data at the tail
    always_ff @(posedge clk_i) begin
        if (!rst_i && !flush_i && push) begin
            res_mem[wr_q] <= boxed;
            st_mem[wr_q]  <= status_i;
            ext_mem[wr_q] <= extension_bit_i;
            tag_mem[wr_q] <= tag_i;
        end
    end

    assign result_o        = res_mem[rd_q];
    assign status_o        = st_mem[rd_q];
    assign extension_bit_o = ext_mem[rd_q];
    assign tag_o           = tag_mem[rd_q];
    assign fflags_o        = fflags_q;
    assign count_o         = cnt_q;
    assign busy_o          = (cnt_q != '0);

endmodule

// File: tb/tb_fpnew_sdotp_result_collector.sv
// Scoreboard bench for the SDOTP result collector: accepted pushes queue
// hand-computed expectations, a negedge monitor checks every pop.
module tb_fpnew_sdotp_result_collector;
    import fpnew_pkg::*;

    localparam int unsigned FLEN  = 64;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    logic            clk = 1'b0;
    logic            rst_i, flush_i, in_valid_i, in_ready_o;
    logic [FLEN-1:0] result_i, result_o;
    status_t         status_i, status_o, fflags_o;
    logic            extension_bit_i, extension_bit_o;
    fp_format_e      dst_fmt_i;
    logic [7:0]      tag_i, tag_o;
    logic            out_valid_o, out_ready_i, fflags_clr_i, busy_o;
    logic [CW-1:0]   count_o;

    fpnew_sdotp_result_collector #(
        .FLEN(FLEN), .FpDstFmtConfig('1), .Depth(DEPTH), .TagType(logic [7:0])
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .result_i(result_i), .status_i(status_i), .extension_bit_i(extension_bit_i),
        .dst_fmt_i(dst_fmt_i), .tag_i(tag_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .result_o(result_o), .status_o(status_o), .extension_bit_o(extension_bit_o),
        .tag_o(tag_o), .fflags_o(fflags_o), .fflags_clr_i(fflags_clr_i),
        .count_o(count_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] r;
        logic [4:0]  s;
        logic        e;
        logic [7:0]  t;
    } exp_t;

    exp_t        q[$];
    logic [63:0] exp_res;
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor and logger: compare each pop against the queue head, and
    // record each push that the DUT will accept at the coming edge.
    always @(negedge clk) begin
        if (!rst_i && out_valid_o && out_ready_i) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_pop: got tag %h expected no output", tag_o);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("pop_result", result_o, e.r);
                chk("pop_status", 64'(status_o), 64'(e.s));
                chk("pop_ext", 64'(extension_bit_o), 64'(e.e));
                chk("pop_tag", 64'(tag_o), 64'(e.t));
            end
        end
        if (!rst_i && !flush_i && in_valid_i && in_ready_o)
            q.push_back('{r: exp_res, s: status_i, e: extension_bit_i, t: tag_i});
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [63:0] r, input logic [63:0] e, input fp_format_e f,
                         input logic [4:0] s, input logic x, input logic [7:0] t);
        result_i        = r;
        exp_res         = e;
        dst_fmt_i       = f;
        status_i        = status_t'(s);
        extension_bit_i = x;
        tag_i           = t;
    endtask

    task automatic push(input logic [63:0] r, input logic [63:0] e, input fp_format_e f,
                        input logic [4:0] s, input logic x, input logic [7:0] t);
        drive(r, e, f, s, x, t);
        in_valid_i = 1'b1;
        step();
        in_valid_i = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
        fflags_clr_i = 1'b0;
        drive(64'h0, 64'h0, FP64, 5'b0, 1'b0, 8'h0);
        step(); step();
        rst_i = 1'b0;
        chk("rst_out_valid", 64'(out_valid_o), 64'd0);
        chk("rst_in_ready", 64'(in_ready_o), 64'd1);
        chk("rst_count", 64'(count_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_fflags", 64'(fflags_o), 64'd0);

        // Boxing vectors, one-cycle latency check on the first
        out_ready_i = 1'b1;
        push(64'h0000_0000_0000_3C00, 64'hFFFF_FFFF_FFFF_3C00, FP16, 5'b00011, 1'b1, 8'h01);
        chk("latency_valid", 64'(out_valid_o), 64'd1);
        chk("latency_count", 64'(count_o), 64'd1);
        push(64'h1234_5678_3F80_0000, 64'hFFFF_FFFF_3F80_0000, FP32, 5'b00000, 1'b0, 8'h02);
        push(64'hAAAA_AAAA_AAAA_AA38, 64'hFFFF_FFFF_FFFF_FF38, FP8, 5'b00000, 1'b1, 8'h03);
        push(64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, FP64, 5'b00000, 1'b0, 8'h04);
        push(64'h5555_0000_0000_3F80, 64'hFFFF_FFFF_FFFF_3F80, FP16ALT, 5'b00000, 1'b0, 8'h05);
        step();
        chk("drain_count", 64'(count_o), 64'd0);

        // Back-pressure and ordering
        out_ready_i = 1'b0;
        push(64'h0000_0000_0000_0011, 64'h0000_0000_0000_0011, FP64, 5'b0, 1'b0, 8'd1);
        push(64'h0000_0000_0000_0022, 64'h0000_0000_0000_0022, FP64, 5'b0, 1'b0, 8'd2);
        chk("full_in_ready", 64'(in_ready_o), 64'd0);
        chk("full_count", 64'(count_o), 64'd2);
        drive(64'h0000_0000_0000_0033, 64'h0000_0000_0000_0033, FP64, 5'b0, 1'b0, 8'd3);
        in_valid_i = 1'b1;
        step(); step();
        chk("held_count", 64'(count_o), 64'd2);
        out_ready_i = 1'b1;
        step();
        chk("pop_when_full_count", 64'(count_o), 64'd1);
        step();
        in_valid_i = 1'b0;
        chk("push_pop_count", 64'(count_o), 64'd1);
        step();
        chk("bp_drain_count", 64'(count_o), 64'd0);

        // Sustained throughput
        for (int i = 0; i < 4; i++) begin
            push(64'(i) << 8, 64'(i) << 8, FP64, 5'b0, 1'b0, 8'(8'h40 + i));
            chk("stream_count", 64'(count_o), 64'd1);
        end
        step();

        // Sticky flags
        fflags_clr_i = 1'b1;
        step();
        fflags_clr_i = 1'b0;
        chk("fflags_cleared", 64'(fflags_o), 64'd0);
        push(64'h1, 64'h1, FP64, 5'b00001, 1'b0, 8'h50);
        push(64'h2, 64'h2, FP64, 5'b10000, 1'b0, 8'h51);
        step();
        chk("fflags_accum", 64'(fflags_o), 64'b10001);
        out_ready_i = 1'b0;
        push(64'h3, 64'h3, FP64, 5'b00100, 1'b0, 8'h52);
        out_ready_i = 1'b1;
        fflags_clr_i = 1'b1;
        step();
        fflags_clr_i = 1'b0;
        chk("fflags_clr_pop", 64'(fflags_o), 64'b00100);
        out_ready_i = 1'b0;
        push(64'h4, 64'h4, FP64, 5'b01000, 1'b0, 8'h53);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        q.delete();
        chk("fflags_flushed", 64'(fflags_o), 64'b00100);
        chk("flush_count", 64'(count_o), 64'd0);

        // Flush with simultaneous push and pop at count 2
        push(64'h10, 64'h10, FP64, 5'b00010, 1'b0, 8'h10);
        push(64'h11, 64'h11, FP64, 5'b00001, 1'b0, 8'h11);
        chk("pre_flush_count", 64'(count_o), 64'd2);
        drive(64'hEE, 64'hEE, FP64, 5'b01000, 1'b0, 8'hEE);
        flush_i = 1'b1; in_valid_i = 1'b1; out_ready_i = 1'b1;
        step();
        flush_i = 1'b0; in_valid_i = 1'b0;
        q.delete();
        chk("flushpp_count", 64'(count_o), 64'd0);
        chk("flushpp_valid", 64'(out_valid_o), 64'd0);
        chk("flushpp_fflags", 64'(fflags_o), 64'b00110);
        step(); step();

        // Flush discards a push the DUT would otherwise accept
        out_ready_i = 1'b0;
        push(64'h20, 64'h20, FP64, 5'b0, 1'b0, 8'h20);
        chk("one_count", 64'(count_o), 64'd1);
        drive(64'h21, 64'h21, FP64, 5'b0, 1'b0, 8'h21);
        flush_i = 1'b1; in_valid_i = 1'b1;
        step();
        flush_i = 1'b0; in_valid_i = 1'b0;
        q.delete();
        chk("flush_drop_count", 64'(count_o), 64'd0);
        out_ready_i = 1'b1;
        step(); step();

        // Reset mid-operation
        out_ready_i = 1'b0;
        push(64'h30, 64'h30, FP64, 5'b0, 1'b0, 8'h30);
        push(64'h31, 64'h31, FP64, 5'b0, 1'b0, 8'h31);
        chk("prereset_count", 64'(count_o), 64'd2);
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        q.delete();
        chk("midrst_count", 64'(count_o), 64'd0);
        chk("midrst_valid", 64'(out_valid_o), 64'd0);
        chk("midrst_fflags", 64'(fflags_o), 64'd0);
        chk("midrst_in_ready", 64'(in_ready_o), 64'd1);
        chk("midrst_busy", 64'(busy_o), 64'd0);

        // Post-reset sanity transfer
        out_ready_i = 1'b1;
        push(64'h0000_0000_0000_BC00, 64'hFFFF_FFFF_FFFF_BC00, FP16, 5'b00001, 1'b1, 8'h60);
        step(); step();
        chk("post_fflags", 64'(fflags_o), 64'b00001);
        chk("queue_empty", 64'(q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/fpnew_sdotp_result_collector.md
# fpnew_sdotp_result_collector

Receiving end of the SDOTP unit's output handshake. Buffers results from the expanding dot-product datapath in a small FIFO and NaN-boxes each result to the full register width according to its destination format. Tracks sticky exception flags from retired results and presents one registered, back-pressurable result stream to the FP register-file writeback.

## Interface

Parameters:
- `FLEN`, 64, width of the result and writeback bus; must be ≥ every enabled destination format width.
- `FpDstFmtConfig`, `'1`, destination formats for which boxing is applied.
- `Depth`, 2, FIFO entries; ≥1, power of two not required.
- `TagType`, `logic`, tag carried unmodified with each result.

Ports:
- `clk_i` in 1: single clock; all state changes on its rising edge.
- `rst_i` in 1: synchronous, active-high reset.
- `flush_i` in 1: drop all buffered results.
- `in_valid_i` in 1: upstream result valid.
- `in_ready_o` out 1: collector can accept.
- `result_i` in FLEN: raw result; only the low `fp_width(dst_fmt_i)` bits are meaningful.
- `status_i` in `fpnew_pkg::status_t`: exception flags of this result.
- `extension_bit_i` in 1: extension bit of this result.
- `dst_fmt_i` in `fpnew_pkg::fp_format_e`: destination format of this result.
- `tag_i` in `TagType`: result tag.
- `out_valid_o` out 1: head entry valid.
- `out_ready_i` in 1: writeback accepts head.
- `result_o` out FLEN: NaN-boxed result.
- `status_o` out `status_t`: flags of head entry.
- `extension_bit_o` out 1: extension bit of head entry.
- `tag_o` out `TagType`: tag of head entry.
- `fflags_o` out `status_t`: sticky OR of the status of every popped result.
- `fflags_clr_i` in 1: clear sticky flags.
- `count_o` out `$clog2(Depth+1)`: current occupancy.
- `busy_o` out 1: `count_o != 0`.

## Operation

- Push when `in_valid_i && in_ready_o`. Pop when `out_valid_o && out_ready_i`.
- `in_ready_o = (count < Depth)`. It never depends combinationally on `out_ready_i`, so there is no ready pass-through. When full, a same-cycle pop does not enable a push.
- Boxing is done at push and the boxed value is stored. For `W = fp_width(dst_fmt_i)`:
  - If `W < FLEN` and the format is enabled in `FpDstFmtConfig`: stored bits `[FLEN-1:W]` are all 1 and bits `[W-1:0]` equal `result_i[W-1:0]`.
  - If the format is disabled or `W ≥ FLEN`: `result_i` is stored unchanged.
- Status, extension bit and tag are stored verbatim with their result.
- Ordering is strict FIFO. Read and write pointers wrap modulo `Depth`.
- Sticky flags update only on a pop, never on a push or on a flushed entry: `fflags_next = (fflags_clr_i ? 0 : fflags) | (pop ? head.status : 0)`. With clear and pop in the same cycle, `fflags_o` ends up equal to the popped status.
- Flush: occupancy goes to 0 and both pointers reset at the clock edge.
  - A push presented in the same cycle as `flush_i` is discarded.
  - A pop in the flush cycle still completes and still updates `fflags`.
  - `fflags` is not cleared by flush.
- Reset (`rst_i = 1` at an edge) has priority over every other input. It clears pointers, count and `fflags`. Stored data is don't-care.
- Head outputs (`result_o`, `status_o`, `extension_bit_o`, `tag_o`) are driven from storage and are don't-care while `out_valid_o = 0`. The bench must not check them then.

## Timing

- Registered outputs with no fall-through. A result pushed at edge *n* is first visible with `out_valid_o = 1` after edge *n*, i.e. one cycle of latency.
- Throughput is one result per cycle sustained when `Depth ≥ 2` and `out_ready_i` is held high. With `Depth = 1`, throughput is one result every two cycles.
- After reset: `out_valid_o = 0`, `in_ready_o = 1`, `count_o = 0`, `busy_o = 0`, `fflags_o = 0`.
- Simultaneous push and pop when not full: count is unchanged and the new entry goes to the tail.
- `out_valid_o` and the head data stay stable while `out_ready_i = 0`; no value changes until the pop.
- `fflags_o` reflects a pop starting in the cycle after the pop handshake.

## Test plan

- **Reset mid-operation:** fill 2 entries, assert `rst_i` for 1 cycle → next cycle `count_o = 0`, `out_valid_o = 0`, `fflags_o = 0`, `in_ready_o = 1`.
- **FP16 boxing:** `FLEN = 64`, `dst_fmt_i = FP16`, `result_i = 64'h0000_0000_0000_3C00` → `result_o = 64'hFFFF_FFFF_FFFF_3C00` one cycle later.
- **FP32 boxing:** `dst_fmt_i = FP32`, `result_i = 64'h1234_5678_3F80_0000` → `result_o = 64'hFFFF_FFFF_3F80_0000`.
- **Back-pressure and ordering:** hold `out_ready_i = 0` and push tags 1 and 2 → `in_ready_o = 0` at `count = 2`; a third `in_valid_i` is held off. Raise `out_ready_i` → tags pop in order 1, 2, then 3, with no loss or duplication.
- **Sticky flags:**
  - Pop status `5'b00001`, then `5'b10000` → `fflags_o = 5'b10001`.
  - Pop `5'b00100` together with `fflags_clr_i` → `fflags_o = 5'b00100`.
  - Push status `5'b01000` and flush before it pops → `fflags_o` unchanged.
- **Flush with simultaneous push and pop:** `count = 2`, assert `flush_i`, `in_valid_i` and `out_ready_i` in one cycle → head pops and updates `fflags`. Next cycle `count_o = 0` and the pushed result never appears.
